// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock-divider controller.
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_GATED = 2'd2
    } clk_div_state_t;

    localparam int unsigned CLK_DIV_MIN = 2;

    // Ratios below the minimum cannot produce both a low and a high phase.
    function automatic int unsigned clk_div_clamp(input int unsigned val);
        return (val < CLK_DIV_MIN) ? CLK_DIV_MIN : val;
    endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Period counter for clk_div_ctrl: produces the end-of-period enable and a
// registered divided clock, low for ceil(N/2) cycles then high for floor(N/2).
module clk_div_counter
    import clk_div_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk_hf,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] cur_div,
    input  logic             load,
    input  logic             hold,
    output logic             wrap,
    output logic             clk_en,
    output logic             clk_out
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W:0]   half;
    logic             clk_out_q;

    assign wrap   = (cnt_q == cur_div - DIV_W'(1));
    assign clk_en = wrap && !hold;

    // One extra bit so the rounding add cannot overflow at the largest ratio.
    assign half = ({1'b0, cur_div} + (DIV_W+1)'(1)) >> 1;

    always_comb begin
        cnt_nxt = cnt_q + DIV_W'(1);
        if (hold || load || wrap) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk_hf or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_nxt;
            clk_out_q <= !hold && ({1'b0, cnt_nxt} >= half);
        end
    end

    assign clk_out = clk_out_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock divider; ratio changes land only on period
// boundaries. Output gating is built only with CLK_DIV_CTRL_GATE_EN defined.
//   state | meaning
//   RUN   | counting at cur_div, may accept a ratio request
//   DRAIN | request captured, finishing the current period at the old ratio
//   GATED | output stopped, counter held at 0 (gating build only)
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk_hf,
    input  logic             rst_n,
    input  logic             div_req,
    input  logic [DIV_W-1:0] div_val,
    output logic             div_ack,
    input  logic             gate_req,
    output logic             gate_ack,
    output logic             clk_en,
    output logic             clk_out,
    output logic [DIV_W-1:0] cur_div,
    output logic             busy
);

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

    clk_div_state_t   state_q, state_nxt;
    logic [DIV_W-1:0] cur_div_q, cur_div_nxt;
    logic [DIV_W-1:0] pend_div_q, pend_div_nxt;
    logic             ack_q, ack_nxt;
    logic [DIV_W-1:0] div_clamped;
    logic             gate_blk;
    logic             accept;
    logic             wrap;
    logic             load;
    logic             hold;

`ifdef CLK_DIV_CTRL_GATE_EN
    assign gate_blk = gate_req;
    assign gate_ack = (state_q == ST_GATED);
`else
    logic unused_gate_req;
    assign unused_gate_req = gate_req;
    assign gate_blk        = 1'b0;
    assign gate_ack        = 1'b0;
`endif

    assign div_clamped = DIV_W'(clk_div_clamp(32'(div_val)));

    // The ack cycle is excluded so a requester that drops div_req on the ack
    // is not taken as a second transaction.
    assign accept = (state_q == ST_RUN) && div_req && !ack_q && !gate_blk;
    assign busy   = (state_q == ST_DRAIN) || accept;
    assign hold   = (state_q == ST_GATED);

    always_comb begin
        state_nxt    = state_q;
        cur_div_nxt  = cur_div_q;
        pend_div_nxt = pend_div_q;
        ack_nxt      = 1'b0;
        load         = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (accept && wrap) begin
                    cur_div_nxt = div_clamped;
                    ack_nxt     = 1'b1;
                    load        = 1'b1;
                end else if (accept) begin
                    pend_div_nxt = div_clamped;
                    state_nxt    = ST_DRAIN;
                end
`ifdef CLK_DIV_CTRL_GATE_EN
                if (gate_req && wrap) begin
                    state_nxt = ST_GATED;
                end
`endif
            end
            ST_DRAIN: begin
                if (wrap) begin
                    cur_div_nxt = pend_div_q;
                    ack_nxt     = 1'b1;
                    load        = 1'b1;
                    state_nxt   = ST_RUN;
                end
            end
`ifdef CLK_DIV_CTRL_GATE_EN
            ST_GATED: begin
                if (!gate_req) begin
                    state_nxt = ST_RUN;
                end
            end
`endif
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_hf or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            cur_div_q  <= DEF_DIV;
            pend_div_q <= DEF_DIV;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cur_div_q  <= cur_div_nxt;
            pend_div_q <= pend_div_nxt;
            ack_q      <= ack_nxt;
        end
    end

    clk_div_counter #(
        .DIV_W (DIV_W)
    ) u_counter (
        .clk_hf  (clk_hf),
        .rst_n   (rst_n),
        .cur_div (cur_div_q),
        .load    (load),
        .hold    (hold),
        .wrap    (wrap),
        .clk_en  (clk_en),
        .clk_out (clk_out)
    );

    assign cur_div = cur_div_q;
    assign div_ack = ack_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus random traffic
// against a period-level reference model (gating checked when CLK_DIV_CTRL_GATE_EN is set).
module tb_clk_div_ctrl;

    localparam int DIV_W = 8;
`ifdef CLK_DIV_CTRL_GATE_EN
    localparam bit GATE_EN = 1'b1;
`else
    localparam bit GATE_EN = 1'b0;
`endif

    logic             clk_hf   = 1'b0;
    logic             rst_n    = 1'b0;
    logic             div_req  = 1'b0;
    logic [DIV_W-1:0] div_val  = '0;
    logic             gate_req = 1'b0;
    logic             div_ack;
    logic             gate_ack;
    logic             clk_en;
    logic             clk_out;
    logic [DIV_W-1:0] cur_div;
    logic             busy;

    clk_div_ctrl #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (4)
    ) dut (
        .clk_hf   (clk_hf),
        .rst_n    (rst_n),
        .div_req  (div_req),
        .div_val  (div_val),
        .div_ack  (div_ack),
        .gate_req (gate_req),
        .gate_ack (gate_ack),
        .clk_en   (clk_en),
        .clk_out  (clk_out),
        .cur_div  (cur_div),
        .busy     (busy)
    );

    always #5 clk_hf = ~clk_hf;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: position within the current period, the ratio in
    // force, an outstanding request and the cycle its ack is due.
    int m_pos;
    int m_n;
    bit m_pend_v;
    int m_pend;
    bit m_gated;
    int m_ack_due;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pos     = 0;
        m_n       = 4;
        m_pend_v  = 1'b0;
        m_pend    = 4;
        m_gated   = 1'b0;
        m_ack_due = -1;
    endtask

    function automatic bit model_accept();
        return !m_gated && !m_pend_v && div_req && (cyc != m_ack_due) && !(GATE_EN && gate_req);
    endfunction

    task automatic compare();
        int half;
        half = (m_n + 1) / 2;
        check_val("clk_en",   32'(clk_en),   32'(!m_gated && (m_pos == m_n - 1)));
        check_val("clk_out",  32'(clk_out),  32'(!m_gated && (m_pos >= half)));
        check_val("cur_div",  32'(cur_div),  32'(m_n));
        check_val("busy",     32'(busy),     32'(m_pend_v || model_accept()));
        check_val("div_ack",  32'(div_ack),  32'(cyc == m_ack_due));
        check_val("gate_ack", 32'(gate_ack), 32'(m_gated));
    endtask

    task automatic advance();
        bit acc;
        bit at_end;
        int v;
        acc    = model_accept();
        at_end = !m_gated && (m_pos == m_n - 1);
        if (acc) begin
            v         = int'(div_val);
            m_pend_v  = 1'b1;
            m_pend    = (v < 2) ? 2 : v;
            m_ack_due = cyc + (m_n - m_pos);
        end
        if (m_gated) begin
            if (!gate_req) m_gated = 1'b0;
        end else if (at_end) begin
            m_pos = 0;
            if (m_pend_v) begin
                m_n      = m_pend;
                m_pend_v = 1'b0;
            end else if (GATE_EN && gate_req) begin
                m_gated = 1'b1;
            end
        end else begin
            m_pos++;
        end
        cyc++;
    endtask

    // Inputs are driven 1 time unit after the rising edge, outputs checked 1 later.
    task automatic tick();
        #1;
        compare();
        @(posedge clk_hf);
        advance();
        #1;
        if (cyc == m_ack_due) div_req = 1'b0;
    endtask

    task automatic finish_req();
        for (int i = 0; i < 600 && div_req; i++) tick();
        if (div_req) begin
            checks++;
            errors++;
            $display("FAIL req_timeout got=pending exp=acked cycle=%0d", cyc);
            div_req = 1'b0;
        end
    endtask

    task automatic run_req(input int val);
        div_req = 1'b1;
        div_val = DIV_W'(val);
        finish_req();
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < 300 && !(m_pos == p && !m_gated); i++) tick();
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk_hf);
        #1;
        compare();
        rst_n = 1'b1;

        // Default ratio 4
        repeat (12) tick();

        // Request 7 mid-period, then watch several 7-cycle periods
        wait_pos(1);
        run_req(7);
        repeat (16) tick();

        // Clamped ratios
        run_req(0);
        repeat (6) tick();
        run_req(1);
        repeat (6) tick();

        // div_val changing while busy is ignored
        wait_pos(0);
        div_req = 1'b1;
        div_val = 8'd9;
        tick();
        div_val = 8'd3;
        finish_req();
        repeat (20) tick();

        // Same ratio again, then a request landing on the wrap cycle
        run_req(9);
        repeat (10) tick();
        wait_pos(8);
        run_req(3);
        repeat (8) tick();

        // Largest ratio, then back to a short one
        run_req(255);
        repeat (260) tick();
        run_req(5);

        // Gate at period start, div request while gated, release
        wait_pos(0);
        gate_req = 1'b1;
        repeat (12) tick();
        div_req = 1'b1;
        div_val = 8'd6;
        repeat (4) tick();
        gate_req = 1'b0;
        finish_req();
        repeat (10) tick();

        // Gate raised during DRAIN
        wait_pos(1);
        div_req = 1'b1;
        div_val = 8'd3;
        tick();
        gate_req = 1'b1;
        finish_req();
        repeat (10) tick();
        gate_req = 1'b0;
        repeat (6) tick();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if (!div_req && $urandom_range(0, 9) == 0) div_req = 1'b1;
            div_val = DIV_W'($urandom_range(0, 12));
            if ($urandom_range(0, 49) == 0) gate_req = ~gate_req;
            tick();
        end
        gate_req = 1'b0;
        finish_req();
        repeat (4) tick();

        // Reset in the middle of a DRAIN toward 12
        run_req(8);
        wait_pos(0);
        div_req = 1'b1;
        div_val = 8'd12;
        tick();
        tick();
        #2;
        rst_n   = 1'b0;
        div_req = 1'b0;
        model_reset();
        #1;
        compare();
        @(posedge clk_hf);
        @(posedge clk_hf);
        #1;
        compare();
        rst_n = 1'b1;
        repeat (12) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
